// File: rtl/obi_sub_regbank_if.sv
// OBI A/R-channel bundle (with parity companions) between the System Control
// manager and the register-bank subordinate.
interface obi_sub_regbank_if #(
  parameter int OBI_AW  = 32,
  parameter int OBI_DW  = 32,
  parameter int OBI_IDW = 1
);
  logic                  obi_req;
  logic                  obi_reqpar;
  logic                  obi_gnt;
  logic                  obi_gntpar;
  logic [OBI_AW-1:0]     obi_addr;
  logic                  obi_we;
  logic [OBI_DW/8-1:0]   obi_be;
  logic [OBI_DW-1:0]     obi_wdata;
  logic [OBI_IDW-1:0]    obi_aid;
  logic                  obi_rvalid;
  logic                  obi_rvalidpar;
  logic                  obi_rready;
  logic                  obi_rreadypar;
  logic [OBI_DW-1:0]     obi_rdata;
  logic [OBI_IDW-1:0]    obi_rid;
  logic                  obi_err;

  modport master (
    output obi_req, obi_reqpar, obi_addr, obi_we, obi_be, obi_wdata, obi_aid,
    output obi_rready, obi_rreadypar,
    input  obi_gnt, obi_gntpar, obi_rvalid, obi_rvalidpar, obi_rdata, obi_rid, obi_err
  );

  modport slave (
    input  obi_req, obi_reqpar, obi_addr, obi_we, obi_be, obi_wdata, obi_aid,
    input  obi_rready, obi_rreadypar,
    output obi_gnt, obi_gntpar, obi_rvalid, obi_rvalidpar, obi_rdata, obi_rid, obi_err
  );
endinterface

// File: rtl/obi_sub_regbank.sv
// OBI subordinate holding NUM_REGS 32-bit R/W registers with byte enables,
// an in-order response FIFO and sticky A/R-channel parity-error detection.
module obi_sub_regbank #(
  parameter int          OBI_AW    = 32,
  parameter int          OBI_DW    = 32,
  parameter int          OBI_IDW   = 1,
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RSP_DEPTH = 2,
  parameter int          CHECK_PAR = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  obi_sub_regbank_if.slave           obi,
  output logic [NUM_REGS*OBI_DW-1:0] regs_o,
  output logic                       par_err_o
);
  localparam int NB = OBI_DW / 8;
  localparam int IW = $clog2(NUM_REGS);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [OBI_AW-1:0] BASE     = OBI_AW'(BASE_ADDR);
  localparam logic [OBI_AW-1:0] SPAN     = OBI_AW'(4 * NUM_REGS);
  localparam logic [CW-1:0]     DEPTH_C  = CW'(RSP_DEPTH);
  localparam logic [PW-1:0]     LAST_PTR = PW'(RSP_DEPTH - 1);

  logic [OBI_DW-1:0]  regs_r      [NUM_REGS];
  logic [OBI_DW-1:0]  fifo_rdata_r[RSP_DEPTH];
  logic [OBI_IDW-1:0] fifo_rid_r  [RSP_DEPTH];
  logic               fifo_err_r  [RSP_DEPTH];
  logic [PW-1:0]      wptr_r, rptr_r;
  logic [CW-1:0]      count_r;
  logic               par_err_r;

  logic [OBI_AW-1:0]  offset_s;
  logic               hit_s, accept_s, pop_s, rvalid_s;
  logic [IW-1:0]      idx_s;
  logic [OBI_DW-1:0]  rsp_rdata_s;
  logic               rsp_err_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) return '0;
    else               return p + PW'(1);
  endfunction

  // A signal and its inverted companion must differ; equality is a parity fault.
  function automatic logic pair_bad(input logic v, input logic vpar);
    return v ~^ vpar;
  endfunction

  assign offset_s = obi.obi_addr - BASE;
  assign hit_s    = (obi.obi_addr >= BASE) && (offset_s < SPAN) && (obi.obi_addr[1:0] == 2'b00);
  assign idx_s    = offset_s[IW+1:2];
  assign rvalid_s = (count_r != '0);
  assign accept_s = obi.obi_req & obi.obi_gnt;
  assign pop_s    = rvalid_s & obi.obi_rready;

  assign obi.obi_gnt       = obi.obi_req & (count_r < DEPTH_C);
  assign obi.obi_gntpar    = ~obi.obi_gnt;
  assign obi.obi_rvalid    = rvalid_s;
  assign obi.obi_rvalidpar = ~rvalid_s;

  // Response payload for the request currently on the A channel.
  always_comb begin
    rsp_rdata_s = '0;
    rsp_err_s   = 1'b1;
    if (hit_s) begin
      rsp_err_s = 1'b0;
      if (!obi.obi_we) rsp_rdata_s = regs_r[idx_s];
      else             rsp_rdata_s = '0;
    end else begin
      rsp_err_s = 1'b1;
    end
  end

  // R-channel outputs come from the FIFO head and read as zero when empty.
  always_comb begin
    obi.obi_rdata = '0;
    obi.obi_rid   = '0;
    obi.obi_err   = 1'b0;
    if (rvalid_s) begin
      obi.obi_rdata = fifo_rdata_r[rptr_r];
      obi.obi_rid   = fifo_rid_r[rptr_r];
      obi.obi_err   = fifo_err_r[rptr_r];
    end else begin
      obi.obi_rdata = '0;
    end
  end

  // Response FIFO: push on acceptance, pop on rvalid & rready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_rdata_r[i] <= '0;
        fifo_rid_r[i]   <= '0;
        fifo_err_r[i]   <= 1'b0;
      end
    end else begin
      if (accept_s) begin
        fifo_rdata_r[wptr_r] <= rsp_rdata_s;
        fifo_rid_r[wptr_r]   <= obi.obi_aid;
        fifo_err_r[wptr_r]   <= rsp_err_s;
        wptr_r               <= ptr_inc(wptr_r);
      end
      if (pop_s) rptr_r <= ptr_inc(rptr_r);
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Register bank with per-byte write enables.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REGS; k++) regs_r[k] <= '0;
    end else if (accept_s && hit_s && obi.obi_we) begin
      for (int b = 0; b < NB; b++) begin
        if (obi.obi_be[b]) regs_r[idx_s][8*b +: 8] <= obi.obi_wdata[8*b +: 8];
      end
    end
  end

  // Sticky parity error; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_err_r <= 1'b0;
    end else if ((CHECK_PAR != 0) &&
                 (pair_bad(obi.obi_req, obi.obi_reqpar) ||
                  pair_bad(obi.obi_rready, obi.obi_rreadypar))) begin
      par_err_r <= 1'b1;
    end
  end

  assign par_err_o = (CHECK_PAR != 0) ? par_err_r : 1'b0;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_o[k*OBI_DW +: OBI_DW] = regs_r[k];
  end
endmodule

// File: tb/tb_obi_sub_regbank.sv
// Self-checking bench for obi_sub_regbank: directed vector table, hand-written
// backpressure/parity/reset sequences and a randomized queue-model phase.
module tb_obi_sub_regbank;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] regs;
  logic         par_err;

  logic        req = 1'b0, req_inj = 1'b0, we = 1'b0, aid = 1'b0;
  logic        rready = 1'b0, rready_inj = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [3:0]  be = 4'h0;

  int checks = 0;
  int errors = 0;

  obi_sub_regbank_if #(.OBI_AW(32), .OBI_DW(32), .OBI_IDW(1)) bus ();

  assign bus.obi_req       = req;
  assign bus.obi_reqpar    = ~req ^ req_inj;
  assign bus.obi_addr      = addr;
  assign bus.obi_we        = we;
  assign bus.obi_be        = be;
  assign bus.obi_wdata     = wdata;
  assign bus.obi_aid       = aid;
  assign bus.obi_rready    = rready;
  assign bus.obi_rreadypar = ~rready ^ rready_inj;

  obi_sub_regbank dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .obi      (bus),
    .regs_o   (regs),
    .par_err_o(par_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        rid;
    logic        err;
  } rsp_t;

  vec_t        tv[11];
  rsp_t        q[$];
  logic [31:0] m[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // One transaction with rready=1; checks the response one cycle after grant.
  task automatic single(input vec_t v, input string name);
    int n;
    @(negedge clk);
    req = 1'b1; we = v.we; addr = v.addr; be = v.be; wdata = v.wdata; aid = v.aid; rready = 1'b1;
    #1;
    n = 0;
    while (!bus.obi_gnt && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n == 20) chk({name, "_gnt_timeout"}, 32'(bus.obi_gnt), 32'd1);
    chk({name, "_rvalid_before"}, 32'(bus.obi_rvalid), 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk({name, "_rvalid"}, 32'(bus.obi_rvalid), 32'd1);
    chk({name, "_rdata"}, bus.obi_rdata, v.exp_rdata);
    chk({name, "_err"}, 32'(bus.obi_err), 32'(v.exp_err));
    chk({name, "_rid"}, 32'(bus.obi_rid), 32'(v.aid));
  endtask

  initial begin
    vec_t v;
    tv[0]  = '{1'b1, 32'h04, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 32'h04, 4'hF, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    tv[2]  = '{1'b1, 32'h04, 4'h2, 32'h0000AB00, 1'b1, 1'b0, 32'h0};
    tv[3]  = '{1'b0, 32'h04, 4'h0, 32'h0,        1'b0, 1'b0, 32'hDEADABEF};
    tv[4]  = '{1'b0, 32'h20, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0};
    tv[5]  = '{1'b0, 32'h06, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0};
    tv[6]  = '{1'b1, 32'h20, 4'hF, 32'h12345678, 1'b0, 1'b1, 32'h0};
    tv[7]  = '{1'b1, 32'h1C, 4'h8, 32'hAA55AA55, 1'b1, 1'b0, 32'h0};
    tv[8]  = '{1'b0, 32'h1C, 4'hF, 32'h0,        1'b1, 1'b0, 32'hAA000000};
    tv[9]  = '{1'b1, 32'h00, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
    tv[10] = '{1'b0, 32'h00, 4'hF, 32'h0,        1'b0, 1'b0, 32'h0};

    // Reset state
    @(posedge clk); @(negedge clk);
    chk("rst_rvalid", 32'(bus.obi_rvalid), 32'd0);
    chk("rst_rvalidpar", 32'(bus.obi_rvalidpar), 32'd1);
    chk("rst_gnt", 32'(bus.obi_gnt), 32'd0);
    chk("rst_gntpar", 32'(bus.obi_gntpar), 32'd1);
    chk("rst_rdata", bus.obi_rdata, 32'd0);
    chk("rst_err", 32'(bus.obi_err), 32'd0);
    chk("rst_regs_zero", 32'(regs == '0), 32'd1);
    chk("rst_par_err", 32'(par_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) single(tv[i], $sformatf("vec%0d", i));
    chk("regs_o_reg1", regs[63:32], 32'hDEADABEF);
    chk("regs_o_reg7", regs[255:224], 32'hAA000000);
    chk("regs_o_reg0", regs[31:0], 32'h0);

    // Backpressure: two acceptances fill the FIFO, third waits for the first pop.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h04; aid = 1'b0; rready = 1'b0;
    #1 chk("bp_gnt1", 32'(bus.obi_gnt), 32'd1);
    @(posedge clk); #1 addr = 32'h1C; aid = 1'b1;
    @(negedge clk);
    chk("bp_gnt2", 32'(bus.obi_gnt), 32'd1);
    chk("bp_rdata_a", bus.obi_rdata, 32'hDEADABEF);
    @(posedge clk); #1 addr = 32'h20; aid = 1'b0;
    @(negedge clk);
    chk("bp_full_gnt", 32'(bus.obi_gnt), 32'd0);
    chk("bp_hold_rvalid", 32'(bus.obi_rvalid), 32'd1);
    @(negedge clk);
    chk("bp_hold_rdata", bus.obi_rdata, 32'hDEADABEF);
    chk("bp_hold_rid", 32'(bus.obi_rid), 32'd0);
    rready = 1'b1;
    #1 chk("bp_gnt_no_pop_dep", 32'(bus.obi_gnt), 32'd0);
    @(negedge clk);
    chk("bp_regrant", 32'(bus.obi_gnt), 32'd1);
    chk("bp_second_rdata", bus.obi_rdata, 32'hAA000000);
    chk("bp_second_rid", 32'(bus.obi_rid), 32'd1);
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    chk("bp_third_rvalid", 32'(bus.obi_rvalid), 32'd1);
    chk("bp_third_err", 32'(bus.obi_err), 32'd1);
    chk("bp_third_rdata", bus.obi_rdata, 32'h0);
    @(negedge clk);
    chk("bp_drained", 32'(bus.obi_rvalid), 32'd0);

    // Parity fault on req: sticky error, transaction still completes.
    @(negedge clk);
    req = 1'b1; req_inj = 1'b1; we = 1'b1; addr = 32'h08; be = 4'hF; wdata = 32'h0BADF00D; aid = 1'b0;
    #1;
    chk("par_gnt", 32'(bus.obi_gnt), 32'd1);
    chk("par_err_before", 32'(par_err), 32'd0);
    @(posedge clk); #1 req = 1'b0; req_inj = 1'b0;
    @(negedge clk);
    chk("par_err_set", 32'(par_err), 32'd1);
    chk("par_rsp_err", 32'(bus.obi_err), 32'd0);
    chk("par_rsp_rvalid", 32'(bus.obi_rvalid), 32'd1);
    repeat (3) @(negedge clk);
    chk("par_err_sticky", 32'(par_err), 32'd1);
    chk("par_reg2", regs[95:64], 32'h0BADF00D);

    // Reset with two responses queued.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h04; aid = 1'b0; rready = 1'b0;
    @(posedge clk); #1 aid = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    chk("rq_queued", 32'(bus.obi_rvalid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rq_rvalid", 32'(bus.obi_rvalid), 32'd0);
    chk("rq_rvalidpar", 32'(bus.obi_rvalidpar), 32'd1);
    chk("rq_regs_zero", 32'(regs == '0), 32'd1);
    chk("rq_par_err", 32'(par_err), 32'd0);
    chk("rq_rdata", bus.obi_rdata, 32'h0);
    v = '{1'b0, 32'h00, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0};
    single(v, "rq_read0");

    // Randomized phase against a queue/array reference model.
    for (int k = 0; k < 8; k++) m[k] = 32'h0;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      logic        exp_gnt;
      int          r;
      logic        vld;
      int          idx;
      rsp_t        e;
      @(negedge clk);
      req    = ($urandom_range(0, 3) != 0);
      we     = $urandom_range(0, 1) == 1;
      be     = 4'($urandom_range(0, 15));
      wdata  = $urandom;
      aid    = $urandom_range(0, 1) == 1;
      rready = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 11);
      if (r < 8)       addr = 32'(r * 4);
      else if (r == 8) addr = 32'h20 + 32'(4 * $urandom_range(0, 3));
      else if (r == 9) addr = 32'hFFFF_FFF0;
      else             addr = 32'(4 * $urandom_range(0, 7) + $urandom_range(1, 3));
      #1;
      exp_gnt = req && (q.size() < 2);
      chk("rnd_gnt", 32'(bus.obi_gnt), 32'(exp_gnt));
      chk("rnd_gntpar", 32'(bus.obi_gntpar), 32'(!exp_gnt));
      chk("rnd_rvalid", 32'(bus.obi_rvalid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("rnd_rdata", bus.obi_rdata, q[0].rdata);
        chk("rnd_rid", 32'(bus.obi_rid), 32'(q[0].rid));
        chk("rnd_err", 32'(bus.obi_err), 32'(q[0].err));
      end
      vld = (addr < 32'h20) && (addr % 4 == 0);
      idx = int'(addr / 4);
      e.rid = aid;
      e.err = !vld;
      e.rdata = (vld && !we) ? m[idx] : 32'h0;
      if (q.size() > 0 && rready) void'(q.pop_front());
      if (exp_gnt) begin
        q.push_back(e);
        if (vld && we)
          for (int b = 0; b < 4; b++) if (be[b]) m[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    @(negedge clk);
    req = 1'b0; rready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rnd_drained", 32'(bus.obi_rvalid), 32'd0);
    for (int k = 0; k < 8; k++) chk($sformatf("rnd_reg%0d", k), regs[k*32 +: 32], m[k]);
    chk("rnd_par_clean", 32'(par_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/obi_sub_regbank.md
Name: obi_sub_regbank

Overview:
- OBI subordinate (responder) that terminates the System Control OBI manager port.
- Holds a bank of NUM_REGS 32-bit read/write registers. Supports byte enables, error responses and A/R-channel parity signalling.
- Buffers up to RSP_DEPTH outstanding responses so the manager can apply rready backpressure without losing data.
- Register contents are exported flat for downstream subsystem control.

Parameters:
- OBI_AW, 32, address width
- OBI_DW, 32, data width (fixed 32; byte lanes = OBI_DW/8)
- OBI_IDW, 1, transaction ID width
- NUM_REGS, 8, number of registers (power of two, 2..64)
- BASE_ADDR, 32'h0000_0000, byte address of register 0
- RSP_DEPTH, 2, response FIFO depth (>=1)
- CHECK_PAR, 1, enable parity-error detection

Ports:
- clk_i  in  1  clock; all logic rising-edge
- rst_i  in  1  synchronous, active-high reset
- obi_req  in  1  A-channel request
- obi_reqpar  in  1  inverse of obi_req
- obi_gnt  out  1  A-channel grant
- obi_gntpar  out  1  inverse of obi_gnt
- obi_addr  in  OBI_AW  byte address
- obi_we  in  1  1=write, 0=read
- obi_be  in  OBI_DW/8  byte enables
- obi_wdata  in  OBI_DW  write data
- obi_aid  in  OBI_IDW  request ID
- obi_rvalid  out  1  R-channel valid
- obi_rvalidpar  out  1  inverse of obi_rvalid
- obi_rready  in  1  R-channel ready
- obi_rreadypar  in  1  inverse of obi_rready
- obi_rdata  out  OBI_DW  read data
- obi_rid  out  OBI_IDW  echoed aid
- obi_err  out  1  error response
- regs_o  out  NUM_REGS*OBI_DW  register contents; reg k at bits [k*32+:32]
- par_err_o  out  1  sticky parity error

Behaviour:
- Reset (rst_i=1 at edge): all registers 0, FIFO emptied, par_err_o=0. After that edge: obi_rvalid=0, obi_rdata=0, obi_rid=0, obi_err=0, regs_o=0. obi_gnt follows its combinational rule; with obi_req=0 it is 0.
- Reset mid-transaction drops all queued responses and pending writes. The manager must reissue them.
- Grant rule: obi_gnt = obi_req & (count < RSP_DEPTH). The rule is combinational, with no dependency on same-cycle pop.
- An acceptance occurs on an edge where obi_req & obi_gnt.
- obi_gntpar = ~obi_gnt and obi_rvalidpar = ~obi_rvalid, always, including during reset.
- Decode: valid when BASE_ADDR <= addr < BASE_ADDR+4*NUM_REGS and addr[1:0]==0. Index = (addr-BASE_ADDR)>>2.
- Accepted valid write: at the acceptance edge, byte i of reg[index] <= wdata byte i where be[i]=1. be=0 is a legal no-op.
  - Response: err=0, rdata=0.
- Accepted valid read: rdata = reg[index] sampled before that edge's write (only one access can be accepted per edge). err=0. be is ignored for reads.
- Invalid address (either type): no register change, rdata=0, err=1.
- Each accepted request pushes {rdata, aid, err} into the FIFO at the acceptance edge.
- Latency: earliest obi_rvalid is the cycle after acceptance.
- Outputs rvalid=(count>0), rdata/rid/err come from the FIFO head. They are held stable while rvalid & ~rready.
- Pop on an edge with obi_rvalid & obi_rready. Simultaneous push and pop leave count unchanged and preserve order.
- Responses return strictly in acceptance order.
- Full FIFO (count==RSP_DEPTH): gnt=0 until a pop edge. Earliest re-grant is the cycle after the pop.
- rready while rvalid=0 is ignored.
- Throughput: with rready held 1, one transaction per cycle is sustained.
- Back-to-back write then read of the same register returns the new value.
- Parity check (CHECK_PAR=1): par_err_o sets on any edge where obi_reqpar==obi_req or obi_rreadypar==obi_rready. Only reset clears it.
  - Parity errors do not block transactions.
  - CHECK_PAR=0 ties par_err_o to 0.
- Widths: count is $clog2(RSP_DEPTH+1) bits and wraps-free by construction. FIFO pointers wrap modulo RSP_DEPTH.

Test Plan:
- Reset, then write addr 0x4, be=4'hF, wdata=0xDEADBEEF, then read 0x4 with rready=1 -> write response rvalid 1 cycle after gnt with err=0. Read returns 0xDEADBEEF. regs_o[63:32]=0xDEADBEEF.
- Partial write be=4'b0010, wdata=0x0000AB00 to reg 1 holding 0xDEADBEEF -> read returns 0xDEADABEF.
- Reads of addr 0x20 (out of range, NUM_REGS=8) and 0x6 (misaligned), aid=1 -> err=1, rdata=0, rid=1. No regs_o change.
- rready=0 with 3 back-to-back reads -> gnt high for 2 acceptances, then 0. rvalid stays 1 with rdata stable. Raising rready drains in order; third request granted the cycle after first pop.
- Drive obi_reqpar=obi_req=1 for one cycle -> par_err_o=1 next cycle and remains 1 until reset. Transaction still completes normally.
- Assert rst_i with 2 responses queued -> rvalid=0 after reset edge, all regs_o=0, par_err_o=0. Subsequent read of reg 0 returns 0.
